pdm_pcm_fifo: RTL and testbench

Sample buffer directly downstream of the PDM CIC decimator inside the PDM microphone peripheral. It synchronises the decimator's `pcm_valid` level into the system clock domain and pushes each new 16-bit PCM word into a small first-word-fall-through FIFO. It exposes the head word and fill level to the register block, and raises an interrupt on a fill threshold or on overflow.

---
 rtl/pdm_pkg.sv | 29 ++
 rtl/pdm_sync2.sv | 21 ++
 rtl/pdm_pcm_fifo.sv | 93 +++++++++
 tb/tb_pdm_pcm_fifo.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pdm_pkg.sv
// pdm_pkg: shared constants for the PDM microphone peripheral.
// Holds the sample format, FIFO depth and FIFO register map.
package pdm_pkg;

    localparam int PCM_W          = 16;
    localparam int PDM_FIFO_DEPTH = 8;

    localparam logic [7:0] REG_FIFO_DATA   = 8'h08;
    localparam logic [7:0] REG_FIFO_STATUS = 8'h0C;

    localparam int ST_EMPTY    = 0;
    localparam int ST_FULL     = 1;
    localparam int ST_OVERFLOW = 2;
    localparam int ST_LEVEL_LO = 8;
    localparam int ST_LEVEL_HI = 11;

    // Packs the FIFO flags into the status register layout.
    function automatic logic [31:0] fifo_status(input logic empty, input logic full,
                                                input logic overflow, input logic [3:0] level);
        logic [31:0] s;
        s = '0;
        s[ST_EMPTY] = empty;
        s[ST_FULL] = full;
        s[ST_OVERFLOW] = overflow;
        s[ST_LEVEL_HI:ST_LEVEL_LO] = level;
        return s;
    endfunction

endpackage

// File: rtl/pdm_sync2.sv
// pdm_sync2: two-flop synchroniser for PDM-domain levels entering the system clock domain.
module pdm_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pdm_pcm_fifo.sv
// pdm_pcm_fifo: synchronises the decimator valid level and buffers PCM words in a
// first-word-fall-through FIFO with level/threshold/overflow status and interrupt.
module pdm_pcm_fifo
    import pdm_pkg::*;
#(
    parameter int DEPTH = PDM_FIFO_DEPTH,
    parameter int PCM_W = pdm_pkg::PCM_W,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PCM_W-1:0] pcm_in,
    input  logic             pcm_valid_in,
    input  logic             enable,
    input  logic             pop,
    input  logic [LVL_W-1:0] threshold,
    input  logic             clear_ovf,
    output logic [PCM_W-1:0] rd_data,
    output logic [LVL_W-1:0] level,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic [7:0]       ovf_count,
    output logic             irq
);

    localparam int IDX_W = LVL_W - 1;

    logic             s2;
    logic             s3;
    logic [LVL_W-1:0] wr_ptr;
    logic [LVL_W-1:0] rd_ptr;
    logic [PCM_W-1:0] mem [DEPTH];
    logic             push_req;
    logic             do_push;
    logic             do_pop;
    logic             ovf_ev;

    pdm_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pcm_valid_in),
        .q     (s2)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s3 <= 1'b0;
        else        s3 <= s2;
    end

    assign push_req = s2 & ~s3;
    assign do_pop   = pop & ~empty;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts the push.
    assign do_push  = push_req & enable & (~full | do_pop);
    assign ovf_ev   = push_req & enable & full & ~do_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (!enable) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[IDX_W-1:0]] <= pcm_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            ovf_count <= '0;
        end else if (ovf_ev) begin
            overflow  <= 1'b1;
            ovf_count <= clear_ovf ? 8'd1 : (ovf_count == 8'hFF) ? ovf_count : ovf_count + 8'd1;
        end else if (clear_ovf) begin
            overflow  <= 1'b0;
            ovf_count <= '0;
        end
    end

    assign level   = wr_ptr - rd_ptr;
    assign empty   = level == '0;
    assign full    = level == LVL_W'(DEPTH);
    assign rd_data = empty ? '0 : mem[rd_ptr[IDX_W-1:0]];
    assign irq     = (threshold != '0 && level >= threshold) || overflow;

endmodule

// File: tb/tb_pdm_pcm_fifo.sv
// tb_pdm_pcm_fifo: directed self-checking bench for pdm_pcm_fifo.
module tb_pdm_pcm_fifo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pcm_in = '0;
    logic        pcm_valid_in = 1'b0;
    logic        enable = 1'b0;
    logic        pop = 1'b0;
    logic [3:0]  threshold = '0;
    logic        clear_ovf = 1'b0;
    logic [15:0] rd_data;
    logic [3:0]  level;
    logic        empty;
    logic        full;
    logic        overflow;
    logic [7:0]  ovf_count;
    logic        irq;

    int total = 0;
    int bad = 0;

    pdm_pcm_fifo dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pcm_in       (pcm_in),
        .pcm_valid_in (pcm_valid_in),
        .enable       (enable),
        .pop          (pop),
        .threshold    (threshold),
        .clear_ovf    (clear_ovf),
        .rd_data      (rd_data),
        .level        (level),
        .empty        (empty),
        .full         (full),
        .overflow     (overflow),
        .ovf_count    (ovf_count),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Valid pulse; optional pop/clear_ovf aligned to the write edge E2.
    task automatic push(input logic [15:0] v, input bit with_pop, input bit with_clr);
        pcm_in = v;
        pcm_valid_in = 1'b1;
        tick;
        tick;
        pop = with_pop;
        clear_ovf = with_clr;
        tick;
        pop = 1'b0;
        clear_ovf = 1'b0;
        tick;
        pcm_valid_in = 1'b0;
        repeat (4) tick;
    endtask

    task automatic do_pop;
        pop = 1'b1;
        tick;
        pop = 1'b0;
    endtask

    initial begin
        repeat (3) tick;
        chk("rst_level", level, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_rd", rd_data, 0);
        chk("rst_irq", irq, 0);
        rst_n = 1'b1;
        enable = 1'b1;
        tick;

        // single sample with 3-edge latency
        pcm_in = 16'h1234;
        pcm_valid_in = 1'b1;
        tick;
        chk("lat_e0", level, 0);
        tick;
        chk("lat_e1", level, 0);
        tick;
        chk("lat_e2", level, 1);
        chk("lat_rd", rd_data, 16'h1234);
        chk("lat_empty", empty, 0);
        repeat (5) tick;
        pcm_valid_in = 1'b0;
        repeat (4) tick;
        chk("one_push", level, 1);
        do_pop;
        chk("pop_level", level, 0);
        chk("pop_rd", rd_data, 0);
        do_pop;
        chk("pop_empty_ign", level, 0);

        // fill with threshold 4
        threshold = 4'd4;
        for (int i = 1; i <= 8; i++) begin
            push(16'(i), 0, 0);
            chk("fill_level", level, i);
            chk("fill_irq", irq, i >= 4);
            chk("fill_full", full, i == 8);
        end
        chk("fill_head", rd_data, 16'h0001);

        // overflow and saturating count
        push(16'hDEAD, 0, 0);
        chk("ovf_flag", overflow, 1);
        chk("ovf_cnt1", ovf_count, 1);
        chk("ovf_head", rd_data, 16'h0001);
        chk("ovf_level", level, 8);
        chk("ovf_irq", irq, 1);
        push(16'hBEEF, 0, 0);
        chk("ovf_cnt2", ovf_count, 2);
        push(16'hBEEF, 0, 1);
        chk("clr_evt_flag", overflow, 1);
        chk("clr_evt_cnt", ovf_count, 1);
        clear_ovf = 1'b1;
        tick;
        clear_ovf = 1'b0;
        chk("clr_flag", overflow, 0);
        chk("clr_cnt", ovf_count, 0);
        chk("clr_irq_lvl", irq, 1);
        threshold = 4'd9;
        #1 chk("thr_gt_depth", irq, 0);
        threshold = 4'd8;
        #1 chk("thr_eq_depth", irq, 1);
        threshold = 4'd0;
        #1 chk("thr_zero", irq, 0);
        threshold = 4'd4;

        // full FIFO, push with pop
        push(16'h0009, 1, 0);
        chk("fp_level", level, 8);
        chk("fp_ovf", overflow, 0);
        chk("fp_head", rd_data, 16'h0002);
        for (int i = 2; i <= 9; i++) begin
            chk("fp_order", rd_data, 16'(i));
            do_pop;
        end
        chk("drain_empty", empty, 1);

        // empty FIFO, push with pop
        push(16'h0055, 1, 0);
        chk("ep_level", level, 1);
        chk("ep_rd", rd_data, 16'h0055);
        do_pop;

        // enable rising under a high valid level
        enable = 1'b0;
        push(16'h0077, 0, 0);
        chk("dis_push", level, 0);
        pcm_valid_in = 1'b1;
        repeat (4) tick;
        enable = 1'b1;
        repeat (4) tick;
        chk("en_rise", level, 0);
        pcm_valid_in = 1'b0;
        repeat (4) tick;

        // flush on enable drop
        for (int i = 0; i < 5; i++) push(16'h0100 + 16'(i), 0, 0);
        chk("pre_flush", level, 5);
        enable = 1'b0;
        tick;
        chk("flush_level", level, 0);
        chk("flush_rd", rd_data, 0);
        enable = 1'b1;
        tick;

        // asynchronous reset mid-stream
        for (int i = 0; i < 8; i++) push(16'h0200 + 16'(i), 0, 0);
        push(16'h0300, 0, 0);
        chk("pre_rst_ovf", overflow, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_level", level, 0);
        chk("arst_empty", empty, 1);
        chk("arst_full", full, 0);
        chk("arst_rd", rd_data, 0);
        chk("arst_ovf", overflow, 0);
        chk("arst_cnt", ovf_count, 0);
        chk("arst_irq", irq, 0);
        tick;
        rst_n = 1'b1;
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
